// File: rtl/rr_mux4_if.sv
// Four valid/ready requester channels sharing one registered output channel.
// The master modport is the producer/consumer side; the slave modport is the arbiter.
interface rr_mux4_if #(
   parameter int unsigned W = 4
);
   logic [3:0]   req_valid;
   logic [W-1:0] d0;
   logic [W-1:0] d1;
   logic [W-1:0] d2;
   logic [W-1:0] d3;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_sel;

   modport master (
      output req_valid, d0, d1, d2, d3, out_ready,
      input  req_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  req_valid, d0, d1, d2, d3, out_ready,
      output req_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter steering one of four requesters through a shared 4:1 mux
// into a single registered output slot with valid/ready backpressure.
module rr_mux4_arbiter #(
   parameter int unsigned W = 4
) (
   input logic    clk,
   input logic    rst_n,
   rr_mux4_if.slave bus
);
   localparam int unsigned N  = 4;
   localparam int unsigned SW = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state;
   logic [W-1:0]  data_q;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] ptr;

   logic          load;
   logic          has_grant;
   logic [SW-1:0] g;
   logic [SW-1:0] idx;
   logic [W-1:0]  selected;

   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

   // Slot is free when empty or being drained this cycle.
   assign load = (state == EMPTY) || bus.out_ready;

   // First valid requester scanning upward from the pointer.
   always_comb begin
      has_grant = 1'b0;
      g         = '0;
      idx       = '0;
      for (int k = 0; k < int'(N); k++) begin
         idx = ptr + SW'(k);
         if (!has_grant && bus.req_valid[idx]) begin
            has_grant = 1'b1;
            g         = idx;
         end
      end
   end

   // Only the granted input reaches the output; X on other inputs is masked.
   always_comb begin
      selected = '0;
      case (g)
         2'd0:    selected = bus.d0;
         2'd1:    selected = bus.d1;
         2'd2:    selected = bus.d2;
         default: selected = bus.d3;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (rst_n && load && has_grant) begin
         bus.req_ready = N'(1) << g;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         data_q <= '0;
         sel_q  <= '0;
         ptr    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (has_grant) begin
                  state  <= FULL;
                  data_q <= selected;
                  sel_q  <= g;
                  ptr    <= g + SW'(1);
               end
            end
            FULL: begin
               if (bus.out_ready) begin
                  if (has_grant) begin
                     data_q <= selected;
                     sel_q  <= g;
                     ptr    <= g + SW'(1);
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule
